// File: rtl/video_attr_serializer.sv
// video_attr_serializer: pixel/attribute output stage.
// Double-buffers one pixel word and one attribute byte per character cell, shifts pixels out
// MSB-first on PIX_CE, applies FLASH inversion and drives registered RGBI.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   PIX_CE            pixel enable; one pixel emitted per asserted cycle
//   D                 fetch bus (pixel word, or attribute in low 8 bits)
//   FETCH_PIX/ATTR    latch D into the stage-1 pixel / attribute register
//   LOAD              cell boundary: stage 1 -> shifter/stage-2 attribute, samples DISPLAY
//   DISPLAY           1 = active area for the cell being loaded, 0 = border
//   BLANK             forces RGBI to 0
//   BORDER            border colour {G,R,B}
//   FRAME             frame pulse, advances the flasher
//   MODE, MONO_ATTR   MODE=1 replaces the cell attribute with MONO_ATTR
//   R, G, B, I        registered colour outputs
//   FLASH             current flasher phase
//   UNDERRUN          sticky: pixel requested with the shifter empty
module video_attr_serializer #(
  parameter int unsigned PIX_W       = 8,
  parameter int unsigned FLASH_DIV   = 16,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned FLASH_CNT_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PIX_CE,
  input  logic [PIX_W-1:0] D,
  input  logic             FETCH_PIX,
  input  logic             FETCH_ATTR,
  input  logic             LOAD,
  input  logic             DISPLAY,
  input  logic             BLANK,
  input  logic [2:0]       BORDER,
  input  logic             FRAME,
  input  logic             MODE,
  input  logic [7:0]       MONO_ATTR,
  output logic             R,
  output logic             G,
  output logic             B,
  output logic             I,
  output logic             FLASH,
  output logic             UNDERRUN
);

  logic [PIX_W-1:0]       pix1_q, pix1_d;
  logic [7:0]             attr1_q, attr1_d;
  logic [PIX_W-1:0]       sr_q, sr_d;
  logic [7:0]             attr2_q, attr2_d;
  logic                   cell_disp_q, cell_disp_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [FLASH_CNT_W-1:0] fcnt_q, fcnt_d;
  logic                   flash_q, flash_d;
  logic                   underrun_q, underrun_d;
  logic [3:0]             rgbi_q, rgbi_d;  // {G,R,B,I}

  logic [7:0] d_attr;
  logic       emit_bit;
  logic [7:0] attr_eff;
  logic       disp_eff;
  logic [7:0] attr_sel;
  logic       ink_sel;

  // Attribute lives in the low 8 bits of D; narrower buses are zero-extended.
  if (PIX_W >= 8) begin : g_attr_wide
    assign d_attr = D[7:0];
  end else begin : g_attr_narrow
    assign d_attr = {{(8 - PIX_W){1'b0}}, D};
  end

  always_comb begin
    pix1_d      = pix1_q;
    attr1_d     = attr1_q;
    sr_d        = sr_q;
    attr2_d     = attr2_q;
    cell_disp_d = cell_disp_q;
    cnt_d       = cnt_q;
    fcnt_d      = fcnt_q;
    flash_d     = flash_q;
    underrun_d  = underrun_q;
    rgbi_d      = rgbi_q;
    emit_bit    = 1'b0;

    if (FETCH_PIX)  pix1_d  = D;
    if (FETCH_ATTR) attr1_d = d_attr;

    // A pixel emitted in the LOAD cycle belongs to the cell being loaded.
    attr_eff = LOAD ? attr1_q : attr2_q;
    disp_eff = LOAD ? DISPLAY : cell_disp_q;

    if (LOAD) begin
      sr_d        = pix1_q;
      attr2_d     = attr1_q;
      cell_disp_d = DISPLAY;
      cnt_d       = '0;
    end

    if (PIX_CE) begin
      if (LOAD) begin
        emit_bit = pix1_q[PIX_W-1];
        sr_d     = pix1_q << 1;
        cnt_d    = CNT_W'(1);
      end else if (cnt_q == CNT_W'(PIX_W)) begin
        // Shifter empty: show paper and flag it until reset.
        emit_bit   = 1'b0;
        underrun_d = 1'b1;
      end else begin
        emit_bit = sr_q[PIX_W-1];
        sr_d     = sr_q << 1;
        cnt_d    = cnt_q + CNT_W'(1);
      end
    end

    attr_sel = MODE ? MONO_ATTR : attr_eff;
    ink_sel  = emit_bit ^ (attr_sel[7] & flash_q);

    if (PIX_CE) begin
      if (BLANK) begin
        rgbi_d = 4'b0000;
      end else if (!disp_eff) begin
        rgbi_d = {BORDER, 1'b0};
      end else begin
        rgbi_d = {(ink_sel ? attr_sel[2:0] : attr_sel[5:3]), attr_sel[6]};
      end
    end

    if (FRAME) begin
      if (fcnt_q == FLASH_CNT_W'(FLASH_DIV - 1)) begin
        fcnt_d  = '0;
        flash_d = ~flash_q;
      end else begin
        fcnt_d = fcnt_q + FLASH_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pix1_q      <= '0;
      attr1_q     <= '0;
      sr_q        <= '0;
      attr2_q     <= '0;
      cell_disp_q <= 1'b0;
      cnt_q       <= CNT_W'(PIX_W);
      fcnt_q      <= '0;
      flash_q     <= 1'b0;
      underrun_q  <= 1'b0;
      rgbi_q      <= '0;
    end else begin
      pix1_q      <= pix1_d;
      attr1_q     <= attr1_d;
      sr_q        <= sr_d;
      attr2_q     <= attr2_d;
      cell_disp_q <= cell_disp_d;
      cnt_q       <= cnt_d;
      fcnt_q      <= fcnt_d;
      flash_q     <= flash_d;
      underrun_q  <= underrun_d;
      rgbi_q      <= rgbi_d;
    end
  end

  assign G        = rgbi_q[3];
  assign R        = rgbi_q[2];
  assign B        = rgbi_q[1];
  assign I        = rgbi_q[0];
  assign FLASH    = flash_q;
  assign UNDERRUN = underrun_q;

endmodule

// File: tb/tb_video_attr_serializer.sv
// Directed bench for video_attr_serializer with an expected-colour scoreboard.
module tb_video_attr_serializer;

  logic       CLK = 1'b0;
  logic       RST, PIX_CE, FETCH_PIX, FETCH_ATTR, LOAD, DISPLAY, BLANK, FRAME, MODE;
  logic [7:0] D, MONO_ATTR;
  logic [2:0] BORDER;
  logic       R, G, B, I, FLASH, UNDERRUN;

  int n_checks = 0;
  int n_fails  = 0;
  logic [3:0] exp_q[$];

  always #5 CLK = ~CLK;

  video_attr_serializer dut (
    .CLK       (CLK),
    .RST       (RST),
    .PIX_CE    (PIX_CE),
    .D         (D),
    .FETCH_PIX (FETCH_PIX),
    .FETCH_ATTR(FETCH_ATTR),
    .LOAD      (LOAD),
    .DISPLAY   (DISPLAY),
    .BLANK     (BLANK),
    .BORDER    (BORDER),
    .FRAME     (FRAME),
    .MODE      (MODE),
    .MONO_ATTR (MONO_ATTR),
    .R         (R),
    .G         (G),
    .B         (B),
    .I         (I),
    .FLASH     (FLASH),
    .UNDERRUN  (UNDERRUN)
  );

  // Expected {G,R,B,I} for an active-area pixel.
  function automatic logic [3:0] col(input logic bit_v, input logic [7:0] a, input logic fl);
    logic s;
    s = bit_v ^ (a[7] & fl);
    return {(s ? a[2:0] : a[5:3]), a[6]};
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1 time unit after the rising edge.
  task automatic cyc(input string tag, input logic rst, input logic ce, input logic ld,
                     input logic fp, input logic fa, input logic frm, input logic [7:0] d,
                     input logic chk, input logic [3:0] exp);
    logic [3:0] e;
    @(negedge CLK);
    RST = rst; PIX_CE = ce; LOAD = ld; FETCH_PIX = fp; FETCH_ATTR = fa; FRAME = frm; D = d;
    if (chk) exp_q.push_back(exp);
    @(posedge CLK);
    #1;
    if (chk) begin
      e = exp_q.pop_front();
      check(tag, {G, R, B, I}, e);
    end
  endtask

  task automatic pix(input string tag, input logic ld, input logic [3:0] exp);
    cyc(tag, 1'b0, 1'b1, ld, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, exp);
  endtask

  task automatic fetch(input logic fp, input logic fa, input logic [7:0] d);
    cyc("fetch", 1'b0, 1'b0, 1'b0, fp, fa, 1'b0, d, 1'b0, 4'h0);
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) cyc("frame", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 4'h0);
  endtask

  initial begin
    logic [7:0] w;
    RST = 1'b0; PIX_CE = 1'b0; FETCH_PIX = 1'b0; FETCH_ATTR = 1'b0; LOAD = 1'b0;
    DISPLAY = 1'b0; BLANK = 1'b0; FRAME = 1'b0; MODE = 1'b0; D = 8'h00;
    MONO_ATTR = 8'h00; BORDER = 3'b000;

    // Reset state
    cyc("rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0);
    cyc("rst_rgbi", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'h0);
    check("rst_flash", {3'b000, FLASH}, 4'h0);
    check("rst_underrun", {3'b000, UNDERRUN}, 4'h0);

    // 1: basic serialisation, ink 111 / paper 001
    fetch(1'b1, 1'b0, 8'hA5);
    fetch(1'b0, 1'b1, 8'h0F);
    DISPLAY = 1'b1;
    w = 8'hA5;
    for (int i = 0; i < 8; i++) pix("t1_pix", i == 0, col(w[7-i], 8'h0F, 1'b0));

    // 2: flash inversion, toggles every FLASH_DIV frames
    fetch(1'b1, 1'b0, 8'hF0);
    fetch(1'b0, 1'b1, 8'hC2);
    frames(15);
    check("t2_flash_15", {3'b000, FLASH}, 4'h0);
    frames(1);
    check("t2_flash_16", {3'b000, FLASH}, 4'h1);
    w = 8'hF0;
    for (int i = 0; i < 8; i++) pix("t2_pix_fl1", i == 0, col(w[7-i], 8'hC2, 1'b1));
    frames(16);
    check("t2_flash_32", {3'b000, FLASH}, 4'h0);
    for (int i = 0; i < 8; i++) pix("t2_pix_fl0", i == 0, col(w[7-i], 8'hC2, 1'b0));

    // 3: border cell with BLANK on pixel 4
    fetch(1'b0, 1'b1, 8'h0F);
    DISPLAY = 1'b0;
    BORDER  = 3'b101;
    for (int i = 0; i < 8; i++) begin
      BLANK = (i == 3);
      pix("t3_border", i == 0, (i == 3) ? 4'b0000 : {3'b101, 1'b0});
    end
    BLANK = 1'b0;

    // 4: underrun after a single LOAD, then recovery
    fetch(1'b1, 1'b0, 8'h81);
    fetch(1'b0, 1'b1, 8'h38);
    DISPLAY = 1'b1;
    w = 8'h81;
    for (int i = 0; i < 8; i++) pix("t4_pix", i == 0, col(w[7-i], 8'h38, 1'b0));
    check("t4_no_underrun", {3'b000, UNDERRUN}, 4'h0);
    pix("t4_underrun_paper", 1'b0, {3'b111, 1'b0});
    check("t4_underrun_set", {3'b000, UNDERRUN}, 4'h1);
    pix("t4_recover0", 1'b1, col(1'b1, 8'h38, 1'b0));
    pix("t4_recover1", 1'b0, col(1'b0, 8'h38, 1'b0));
    check("t4_underrun_sticky", {3'b000, UNDERRUN}, 4'h1);

    // 5: FETCH_PIX coinciding with LOAD shifts the old word
    cyc("t5_load_fetch", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b1,
        col(1'b1, 8'h38, 1'b0));
    for (int i = 1; i < 8; i++) pix("t5_old_word", 1'b0, col(w[7-i], 8'h38, 1'b0));
    pix("t5_new0", 1'b1, col(1'b1, 8'h38, 1'b0));
    pix("t5_new1", 1'b0, col(1'b1, 8'h38, 1'b0));
    // Monochrome override mid-cell
    MODE = 1'b1;
    MONO_ATTR = 8'h47;
    pix("t5_mono", 1'b0, col(1'b1, 8'h47, 1'b0));
    MODE = 1'b0;

    // 6: reset mid-cell with FLASH=1 and UNDERRUN=1
    frames(16);
    check("t6_flash_pre", {3'b000, FLASH}, 4'h1);
    pix("t6_pix1", 1'b1, col(1'b1, 8'h38, 1'b1));
    pix("t6_pix2", 1'b0, col(1'b1, 8'h38, 1'b1));
    cyc("t6_rst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'h0);
    check("t6_rst_flash", {3'b000, FLASH}, 4'h0);
    check("t6_rst_underrun", {3'b000, UNDERRUN}, 4'h0);
    pix("t6_empty_border", 1'b0, {3'b101, 1'b0});
    check("t6_underrun_after_rst", {3'b000, UNDERRUN}, 4'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
